ctl_seq: RTL and testbench

CTL_SEQ -- requirements
Module: ctl_seq

---
 rtl/ctl_seq_pkg.sv | 19 +
 rtl/ctl_seq_if.sv | 35 +++
 rtl/ctl_beat_gen.sv | 19 +
 rtl/ctl_seq.sv | 138 +++++++++++++
 tb/tb_ctl_seq.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ctl_seq_pkg.sv
// Shared types and console mode codes for the control sequencer.
package ctl_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CON,
    ST_FETCH0,
    ST_EXEC,
    ST_INTC,
    ST_HALT
  } state_e;

  localparam logic [2:0] MODE_RUN    = 3'b000;
  localparam logic [2:0] MODE_WR_MEM = 3'b001;
  localparam logic [2:0] MODE_RD_MEM = 3'b010;
  localparam logic [2:0] MODE_RD_REG = 3'b011;
  localparam logic [2:0] MODE_WR_REG = 3'b100;

endpackage

// File: rtl/ctl_seq_if.sv
// Console/decoder bundle between the sequencer (slave) and its surroundings (master).
interface ctl_seq_if #(
  parameter int NBEAT = 3,
  parameter int NREG  = 4,
  parameter int SWW   = 3
);
  localparam int RW = $clog2(NREG);

  logic [SWW-1:0]   sw;
  logic             start;
  logic             short_op;
  logic             long_op;
  logic             halt_req;
  logic             int_req;
  logic             ei;
  logic             di;

  logic [NBEAT-1:0] w;
  logic             st0;
  logic             stop;
  logic [RW-1:0]    reg_idx;
  logic             inta;
  logic             ie;
  logic [SWW-1:0]   mode;

  modport master (
    output sw, start, short_op, long_op, halt_req, int_req, ei, di,
    input  w, st0, stop, reg_idx, inta, ie, mode
  );

  modport slave (
    input  sw, start, short_op, long_op, halt_req, int_req, ei, di,
    output w, st0, stop, reg_idx, inta, ie, mode
  );
endinterface

// File: rtl/ctl_beat_gen.sv
// One-hot beat ring: holds, advances one position, or restarts at W[1].
module ctl_beat_gen #(
  parameter int NBEAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             advance,
  output logic [NBEAT-1:0] w
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          w <= NBEAT'(1);
    else if (restart) w <= NBEAT'(1);
    else if (advance) w <= {w[NBEAT-2:0], w[NBEAT-1]};
  end

endmodule

// File: rtl/ctl_seq.sv
// Instruction/console control sequencer: fetch, variable-length execute, interrupt cycle, halt, console steps.
module ctl_seq
  import ctl_seq_pkg::*;
#(
  parameter int NBEAT = 3,
  parameter int NREG  = 4,
  parameter int SWW   = 3
) (
  input logic    t3,
  input logic    clr,
  ctl_seq_if.slave bus
);

  localparam int RW      = $clog2(NREG);
  localparam bit LONG_OK = (NBEAT > 2);

  state_e           state, state_n;
  logic [NBEAT-1:0] w;
  logic             st0, ie, con_step, halt_seen;
  logic [SWW-1:0]   mode;
  logic [RW-1:0]    reg_idx;

  logic restart, advance, end_beat, halt_now, take_int;
  logic latch_mode, st0_set, con_go, con_done, intc_enter;
  logic mode_mem, mode_reg;

  function automatic logic sw_legal(input logic [SWW-1:0] s);
    return s == SWW'(MODE_RUN)    || s == SWW'(MODE_WR_MEM) ||
           s == SWW'(MODE_RD_MEM) || s == SWW'(MODE_RD_REG) ||
           s == SWW'(MODE_WR_REG);
  endfunction

  assign mode_mem = (mode == SWW'(MODE_WR_MEM)) || (mode == SWW'(MODE_RD_MEM));
  assign mode_reg = (mode == SWW'(MODE_RD_REG)) || (mode == SWW'(MODE_WR_REG));

  // SHORT is only honoured at W[1] and LONG only at W[2]; past W[2] the ring runs to W[NBEAT].
  assign end_beat = w[0] ? bus.short_op
                  : w[1] ? !(bus.long_op && LONG_OK)
                  :        w[NBEAT-1];
  assign halt_now = halt_seen | bus.halt_req;
  assign take_int = bus.int_req & ie;

  ctl_beat_gen #(.NBEAT(NBEAT)) u_beat (
    .clk     (t3),
    .rst     (clr),
    .restart (restart),
    .advance (advance),
    .w       (w)
  );

  always_ff @(posedge t3 or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    restart    = 1'b1;
    advance    = 1'b0;
    latch_mode = 1'b0;
    st0_set    = 1'b0;
    con_go     = 1'b0;
    con_done   = 1'b0;
    intc_enter = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && sw_legal(bus.sw)) begin
          latch_mode = 1'b1;
          state_n    = (bus.sw == SWW'(MODE_RUN)) ? ST_FETCH0 : ST_CON;
        end
      end
      ST_CON: begin
        if (con_step)       con_done = 1'b1;
        else if (bus.start) con_go   = 1'b1;
      end
      ST_FETCH0: begin
        st0_set = 1'b1;
        state_n = ST_EXEC;
      end
      ST_EXEC: begin
        if (end_beat) begin
          if (halt_now) state_n = ST_HALT;
          else if (take_int) begin
            state_n    = ST_INTC;
            intc_enter = 1'b1;
          end
        end else begin
          restart = 1'b0;
          advance = 1'b1;
        end
      end
      ST_INTC: begin
        if (w[1]) state_n = ST_EXEC;
        else begin
          restart = 1'b0;
          advance = 1'b1;
        end
      end
      ST_HALT: begin
        if (bus.start) state_n = ST_EXEC;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge t3 or posedge clr) begin
    if (clr) begin
      mode      <= '0;
      st0       <= 1'b0;
      ie        <= 1'b0;
      con_step  <= 1'b0;
      halt_seen <= 1'b0;
      reg_idx   <= '0;
    end else begin
      if (latch_mode) mode <= bus.sw;
      if (st0_set || (con_done && mode_mem)) st0 <= 1'b1;
      if (con_go)        con_step <= 1'b1;
      else if (con_done) con_step <= 1'b0;
      if (con_done && mode_reg) reg_idx <= reg_idx + RW'(1);
      // Halt request is remembered across beats and dropped once the instruction ends.
      if (state == ST_EXEC) halt_seen <= end_beat ? 1'b0 : halt_now;
      // Entering the interrupt cycle and DI both beat a simultaneous EI.
      if (intc_enter || bus.di) ie <= 1'b0;
      else if (bus.ei)          ie <= 1'b1;
    end
  end

  assign bus.w       = w;
  assign bus.st0     = st0;
  assign bus.ie      = ie;
  assign bus.mode    = mode;
  assign bus.reg_idx = reg_idx;
  assign bus.inta    = (state == ST_INTC) && w[0];
  assign bus.stop    = (state == ST_IDLE) || (state == ST_HALT) ||
                       ((state == ST_CON) && !con_step);

endmodule

// File: tb/tb_ctl_seq.sv
// Directed bench for ctl_seq with NBEAT=3, NREG=4, SWW=3.
module tb_ctl_seq;

  logic t3;
  logic clr;
  int   n_tests = 0;
  int   n_fail  = 0;

  ctl_seq_if #(.NBEAT(3), .NREG(4), .SWW(3)) bus ();

  ctl_seq #(.NBEAT(3), .NREG(4), .SWW(3)) dut (
    .t3  (t3),
    .clr (clr),
    .bus (bus)
  );

  initial t3 = 1'b0;
  always #5 t3 = ~t3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge t3);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr          = 1'b1;
    bus.sw       = 3'b000;
    bus.start    = 1'b0;
    bus.short_op = 1'b0;
    bus.long_op  = 1'b0;
    bus.halt_req = 1'b0;
    bus.int_req  = 1'b0;
    bus.ei       = 1'b0;
    bus.di       = 1'b0;
    tick();
    tick();
    check("rst_w",    bus.w, 3'b001);
    check("rst_st0",  bus.st0, 0);
    check("rst_stop", bus.stop, 1);
    check("rst_ie",   bus.ie, 0);
    check("rst_inta", bus.inta, 0);
    check("rst_idx",  bus.reg_idx, 0);
    check("rst_mode", bus.mode, 0);
    clr = 1'b0;

    // Illegal console code is ignored
    bus.sw = 3'b111; bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("ill_stop", bus.stop, 1);
    check("ill_mode", bus.mode, 0);

    // Run: fetch, then short-form execute
    bus.sw = 3'b000; bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("f0_w",    bus.w, 3'b001);
    check("f0_st0",  bus.st0, 0);
    check("f0_stop", bus.stop, 0);
    tick(); check("ex_w1a", bus.w, 3'b001); check("ex_st0", bus.st0, 1);
    tick(); check("ex_w2a", bus.w, 3'b010);
    tick(); check("ex_w1b", bus.w, 3'b001);
    tick(); check("ex_w2b", bus.w, 3'b010);
    // LONG at W[2] runs to W[3]
    bus.long_op = 1'b1; tick(); bus.long_op = 1'b0;
    check("long_w3", bus.w, 3'b100);
    tick(); check("long_w1", bus.w, 3'b001);
    // SHORT+LONG at W[1]: SHORT wins
    bus.short_op = 1'b1; bus.long_op = 1'b1; tick();
    bus.short_op = 1'b0; bus.long_op = 1'b0;
    check("short_w1", bus.w, 3'b001);

    // Interrupt cycle
    bus.ei = 1'b1; tick(); bus.ei = 1'b0;
    check("ei_ie", bus.ie, 1);
    check("ei_w2", bus.w, 3'b010);
    bus.int_req = 1'b1; tick(); bus.int_req = 1'b0;
    check("intc_inta", bus.inta, 1);
    check("intc_ie",   bus.ie, 0);
    check("intc_w1",   bus.w, 3'b001);
    check("intc_stop", bus.stop, 0);
    tick(); check("intc_w2", bus.w, 3'b010); check("intc_inta2", bus.inta, 0);
    tick(); check("intc_ret_w", bus.w, 3'b001); check("intc_ret_inta", bus.inta, 0);
    tick(); check("intc_ret_w2", bus.w, 3'b010);

    // Halt beats pending interrupt; interrupt taken after resume
    bus.ei = 1'b1; tick(); bus.ei = 1'b0;
    check("h_ie", bus.ie, 1);
    bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
    check("h_w2", bus.w, 3'b010);
    bus.int_req = 1'b1; tick();
    check("halt_stop", bus.stop, 1);
    check("halt_w",    bus.w, 3'b001);
    check("halt_st0",  bus.st0, 1);
    check("halt_inta", bus.inta, 0);
    check("halt_ie",   bus.ie, 1);
    tick(); check("halt_hold", bus.stop, 1);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("resume_stop", bus.stop, 0);
    check("resume_w",    bus.w, 3'b001);
    tick(); check("resume_w2", bus.w, 3'b010);
    tick(); bus.int_req = 1'b0;
    check("pend_inta", bus.inta, 1);
    check("pend_ie",   bus.ie, 0);
    tick(); tick(); check("pend_ret_w", bus.w, 3'b001);

    // EI and DI together: DI wins
    bus.ei = 1'b1; tick(); check("ei2_ie", bus.ie, 1);
    bus.di = 1'b1; tick(); bus.ei = 1'b0; bus.di = 1'b0;
    check("eidi_ie", bus.ie, 0);

    // Register write mode walks REG_IDX
    do_clr();
    bus.sw = 3'b100; bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("reg_stop", bus.stop, 1);
    check("reg_mode", bus.mode, 3'b100);
    bus.sw = 3'b000;
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      check("reg_step_stop", bus.stop, 0);
      check("reg_step_w", bus.w, 3'b001);
      tick();
      check("reg_idx", bus.reg_idx, (i + 1) % 4);
      check("reg_st0", bus.st0, 0);
      check("reg_wait_stop", bus.stop, 1);
    end
    check("reg_mode_kept", bus.mode, 3'b100);

    // Memory read mode: AR load then increment
    do_clr();
    bus.sw = 3'b010; bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("mem_con_st0", bus.st0, 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("mem_s1_st0",  bus.st0, 0);
    check("mem_s1_stop", bus.stop, 0);
    tick();
    check("mem_s1e_st0",  bus.st0, 1);
    check("mem_s1e_stop", bus.stop, 1);
    check("mem_idx",      bus.reg_idx, 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("mem_s2_st0", bus.st0, 1);
    tick(); check("mem_s2e_stop", bus.stop, 1);

    // CLR mid-execute at W[2]
    do_clr();
    bus.sw = 3'b000; bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.ei = 1'b1; tick(); bus.ei = 1'b0;
    check("ab_ie", bus.ie, 1);
    tick(); check("ab_w2", bus.w, 3'b010);
    clr = 1'b1; #1;
    check("ab_w",    bus.w, 3'b001);
    check("ab_st0",  bus.st0, 0);
    check("ab_ie0",  bus.ie, 0);
    check("ab_stop", bus.stop, 1);
    check("ab_inta", bus.inta, 0);
    check("ab_mode", bus.mode, 0);
    tick(); tick(); clr = 1'b0;
    tick(); tick();
    check("ab_idle_stop", bus.stop, 1);
    check("ab_idle_inta", bus.inta, 0);
    check("ab_idle_w",    bus.w, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
